doodle_jump_engine: RTL

- Parametrised successor of the doodle game state machine.
- Runs the full jump/fall/scroll physics of the player sprite, advancing once per frame tick, and detects landings against NUM_PLAT platforms supplied by the platform generator.
- Keeps the sprite at or below SCROLL_LINE by emitting per-frame scroll amounts, and accumulates score; the renderer consumes doodle_x/doodle_y/scroll_dy.
- Sits between the VGA timing block (frame tick) and the platform generator/renderer.

---
 rtl/doodle_jump_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/doodle_jump_engine.sv
// rtl/doodle_jump_engine.sv - jump/fall/scroll physics and platform landing for the doodle sprite
module doodle_jump_engine #(
   parameter int POS_W       = 10,
   parameter int SCORE_W     = 16,
   parameter int NUM_PLAT    = 8,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int DOODLE_W    = 32,
   parameter int DOODLE_H    = 32,
   parameter int PLAT_W      = 64,
   parameter int JUMP_H      = 120,
   parameter int V_STEP      = 4,
   parameter int H_STEP      = 4,
   parameter int SCROLL_LINE = 240,
   parameter int X_START     = 304,
   parameter int Y_START     = 400
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         Start,
   input  logic                         Ack,
   input  logic                         Tick,
   input  logic                         Left,
   input  logic                         Right,
   input  logic [NUM_PLAT*POS_W-1:0]    plat_x,
   input  logic [NUM_PLAT*POS_W-1:0]    plat_y,
   output logic [POS_W-1:0]             doodle_x,
   output logic [POS_W-1:0]             doodle_y,
   output logic [POS_W-1:0]             scroll_dy,
   output logic                         scroll_vld,
   output logic                         landed,
   output logic [$clog2(NUM_PLAT)-1:0]  landed_idx,
   output logic [SCORE_W-1:0]           score,
   output logic                         q_I,
   output logic                         q_Up,
   output logic                         q_Down,
   output logic                         q_Done
);

   localparam int IDX_W = $clog2(NUM_PLAT);
   localparam int W1    = POS_W + 1;
   localparam int SW1   = SCORE_W + 1;

   typedef enum logic [1:0] {S_I, S_UP, S_DOWN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   x_q, x_d, y_q, y_d, sdy_q, sdy_d;
   logic               svld_q, svld_d, landed_q, landed_d;
   logic [IDX_W-1:0]   lidx_q, lidx_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [W1-1:0]      rise_q, rise_d;

   logic [W1-1:0]       ob, nb, x_right;
   logic [NUM_PLAT-1:0] hit;
   logic                hit_any;
   logic [IDX_W-1:0]    hit_idx;
   logic [POS_W-1:0]    hit_py;
   logic [SW1-1:0]      score_sum;

   // old/new sprite bottom and right edge, widened so the compares never wrap
   always_comb begin
      ob      = W1'(y_q) + W1'(DOODLE_H);
      nb      = ob + W1'(V_STEP);
      x_right = W1'(x_q) + W1'(DOODLE_W);
   end

   for (genvar g = 0; g < NUM_PLAT; g++) begin : g_hit
      logic [W1-1:0] px_w, py_w;
      assign px_w   = W1'(plat_x[g*POS_W +: POS_W]);
      assign py_w   = W1'(plat_y[g*POS_W +: POS_W]);
      assign hit[g] = (x_right > px_w) && (W1'(x_q) < px_w + W1'(PLAT_W)) &&
                      (ob <= py_w) && (nb >= py_w);
   end

   // pick the lowest-index platform hit this frame
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      hit_py  = '0;
      for (int i = NUM_PLAT - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
            hit_py  = plat_y[i*POS_W +: POS_W];
         end
      end
   end

   // next-state and physics for one frame; nothing but Start/Ack moves outside Tick
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      sdy_d     = sdy_q;
      svld_d    = 1'b0;
      landed_d  = 1'b0;
      lidx_d    = lidx_q;
      score_d   = score_q;
      rise_d    = rise_q;
      score_sum = '0;
      case (state_q)
         S_I: begin
            if (Start) begin
               state_d = S_UP;
               x_d     = POS_W'(X_START);
               y_d     = POS_W'(Y_START);
               score_d = '0;
               rise_d  = '0;
            end
         end
         S_DONE: begin
            if (Ack) state_d = S_I;
         end
         default: begin
            if (Tick) begin
               if (state_q == S_UP) begin
                  // rising past the scroll line pins the sprite and scrolls the world instead
                  if (W1'(y_q) < W1'(SCROLL_LINE + V_STEP)) begin
                     y_d       = POS_W'(SCROLL_LINE);
                     sdy_d     = POS_W'(W1'(SCROLL_LINE + V_STEP) - W1'(y_q));
                     svld_d    = 1'b1;
                     score_sum = {1'b0, score_q} + SW1'(sdy_d);
                     score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                  end else begin
                     y_d = y_q - POS_W'(V_STEP);
                  end
                  rise_d = rise_q + W1'(V_STEP);
                  if (rise_d >= W1'(JUMP_H)) state_d = S_DOWN;
               end else begin
                  if (hit_any) begin
                     y_d      = hit_py - POS_W'(DOODLE_H);
                     rise_d   = '0;
                     landed_d = 1'b1;
                     lidx_d   = hit_idx;
                     state_d  = S_UP;
                  end else if (nb >= W1'(V_RES)) begin
                     state_d = S_DONE;
                  end else begin
                     y_d = y_q + POS_W'(V_STEP);
                  end
               end
               if (Left && !Right) begin
                  x_d = (x_q < POS_W'(H_STEP)) ? POS_W'(H_RES - DOODLE_W) : x_q - POS_W'(H_STEP);
               end else if (Right && !Left) begin
                  x_d = (W1'(x_q) + W1'(H_STEP) > W1'(H_RES - DOODLE_W)) ? '0 : x_q + POS_W'(H_STEP);
               end
            end
         end
      endcase
   end

   // state and physics registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_I;
         x_q      <= POS_W'(X_START);
         y_q      <= POS_W'(Y_START);
         sdy_q    <= '0;
         svld_q   <= 1'b0;
         landed_q <= 1'b0;
         lidx_q   <= '0;
         score_q  <= '0;
         rise_q   <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         sdy_q    <= sdy_d;
         svld_q   <= svld_d;
         landed_q <= landed_d;
         lidx_q   <= lidx_d;
         score_q  <= score_d;
         rise_q   <= rise_d;
      end
   end

   assign doodle_x   = x_q;
   assign doodle_y   = y_q;
   assign scroll_dy  = sdy_q;
   assign scroll_vld = svld_q;
   assign landed     = landed_q;
   assign landed_idx = lidx_q;
   assign score      = score_q;
   assign q_I        = (state_q == S_I);
   assign q_Up       = (state_q == S_UP);
   assign q_Down     = (state_q == S_DOWN);
   assign q_Done     = (state_q == S_DONE);

endmodule
